// File: rtl/muxnx1_rr_pipe.sv
// muxnx1_rr_pipe: N:1 round-robin mux with a registered valid/ready output stage.
// Define MUXNX1_LOCK_EN to add in_lock, which pins the arbiter to a channel across a multi-word burst.
module muxnx1_rr_pipe #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
`ifdef MUXNX1_LOCK_EN
    input  logic [N-1:0]       in_lock,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel
);
    logic [SEL_W-1:0] ptr, grant, cand;
    logic found, slot_free, xfer;
`ifdef MUXNX1_LOCK_EN
    logic locked;
    logic [SEL_W-1:0] lock_g;
`endif
    assign slot_free = !out_valid || out_ready;
    // Scanning from ptr+N-1 down to ptr leaves the first valid channel at or after ptr as the final hit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = SEL_W'((int'(ptr) + i) % N);
            if (in_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
`ifdef MUXNX1_LOCK_EN
        if (locked) begin
            grant = lock_g;
            found = in_valid[lock_g];
        end
`endif
    end
    assign xfer     = found && slot_free && !rst;
    assign in_ready = xfer ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
`ifdef MUXNX1_LOCK_EN
            locked    <= 1'b0;
            lock_g    <= '0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_sel   <= grant;
            ptr       <= (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
`ifdef MUXNX1_LOCK_EN
            locked    <= in_lock[grant];
            lock_g    <= grant;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_muxnx1_rr_pipe.sv
// tb_muxnx1_rr_pipe: scoreboard bench for muxnx1_rr_pipe (N=4/WIDTH=8 main instance, N=3/WIDTH=16 side instance).
module tb_muxnx1_rr_pipe;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;
`ifdef MUXNX1_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   lock = '0;
    logic [N*W-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;

    logic [2:0]  v3 = '0;
    logic [2:0]  rdy3;
    logic [47:0] d3 = '0;
    logic        ov3;
    logic        r3 = 1'b1;
    logic [15:0] od3;
    logic [1:0]  os3;

    muxnx1_rr_pipe #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef MUXNX1_LOCK_EN
        .in_lock(lock),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
    );

    muxnx1_rr_pipe #(.N(3), .WIDTH(16)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
`ifdef MUXNX1_LOCK_EN
        .in_lock(3'b000),
`endif
        .out_valid(ov3), .out_ready(r3), .out_data(od3), .out_sel(os3)
    );

    typedef struct {
        logic [SW-1:0] sel;
        logic [W-1:0]  data;
    } word_t;

    int checks = 0;
    int errors = 0;
    word_t sb[$];
    logic [SW-1:0] obs_sel[$];
    logic [W-1:0]  obs_data[$];
    int exp_sel[8];

    // Reference model: round-robin pointer, occupancy of the output slot, and lock owner.
    int m_ptr = 0;
    bit m_valid = 1'b0;
    bit m_lock = 1'b0;
    int m_lock_g = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r, input logic [N-1:0] lk, input logic [N*W-1:0] d);
        int g;
        bit found;
        bit slot;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        in_valid  = v;
        out_ready = r;
        lock      = lk;
        in_data   = d;
        #1;
        g = 0;
        found = 1'b0;
        if (m_lock) begin
            g = m_lock_g;
            found = v[g];
        end else begin
            for (int i = 0; i < N; i++) begin
                if (v[(m_ptr + i) % N]) begin
                    g = (m_ptr + i) % N;
                    found = 1'b1;
                    break;
                end
            end
        end
        slot = !m_valid || r;
        exp_rdy = (found && slot) ? N'(1 << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (found && slot) begin
            sb.push_back('{sel: SW'(g), data: d[g*W +: W]});
            m_valid  = 1'b1;
            m_ptr    = (g + 1) % N;
            m_lock   = LOCK_EN && lk[g];
            m_lock_g = g;
        end else if (r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive('0, 1'b1, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        sb.delete();
        m_ptr = 0;
        m_valid = 1'b0;
        m_lock = 1'b0;
        in_valid = '0;
        @(negedge clk);
        #4;
        rst = 1'b0;
    endtask

    task automatic cmp_obs(input string nm, input int n);
        chk({nm, "_count"}, 32'(obs_sel.size()), 32'(n));
        for (int i = 0; i < n && i < obs_sel.size(); i++) chk({nm, "_sel"}, 32'(obs_sel[i]), 32'(exp_sel[i]));
        obs_sel.delete();
        obs_data.delete();
    endtask

    // Monitor: a word is new when out_valid is high and the previous word was not left waiting.
    initial begin
        bit held = 1'b0;
        word_t last;
        last = '{sel: '0, data: '0};
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (out_valid && !held) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got sel=%0d data=%0h expected no word", out_sel, out_data);
                end else begin
                    last = sb.pop_front();
                    chk("out_sel", 32'(out_sel), 32'(last.sel));
                    chk("out_data", 32'(out_data), 32'(last.data));
                end
                obs_sel.push_back(out_sel);
                obs_data.push_back(out_data);
            end else if (out_valid) begin
                chk("hold_sel", 32'(out_sel), 32'(last.sel));
                chk("hold_data", 32'(out_data), 32'(last.data));
            end
            held = out_valid && !out_ready;
        end
    end

    initial begin
        do_reset();
        idle(1);
        drive(4'b0100, 1'b1, '0, 32'h00A5_0000);
        idle(2);
        exp_sel = '{2, 0, 0, 0, 0, 0, 0, 0};
        chk("first_data", 32'(obs_data.size() > 0 ? obs_data[0] : 8'h00), 32'hA5);
        cmp_obs("after_reset", 1);

        do_reset();
        for (int i = 0; i < 5; i++) drive(4'hF, 1'b1, '0, 32'h1312_1110);
        idle(2);
        for (int i = 0; i < obs_sel.size(); i++) chk("contention_data", 32'(obs_data[i]), 32'h10 + 32'(obs_sel[i]));
        exp_sel = '{0, 1, 2, 3, 0, 0, 0, 0};
        cmp_obs("contention", 5);

        drive(4'hF, 1'b1, '0, 32'h2423_2221);
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, 1'b0, '0, 32'h2423_2221);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        drive(4'hF, 1'b1, '0, 32'h2423_2221);
        chk("bp_release_ready", 32'(in_ready != '0), 1);
        idle(2);
        obs_sel.delete();
        obs_data.delete();

        do_reset();
        drive(4'b1000, 1'b1, '0, 32'h5500_0000);
        for (int i = 0; i < 3; i++) drive(4'b1010, 1'b1, '0, 32'h6600_6600);
        idle(2);
        exp_sel = '{3, 1, 3, 1, 0, 0, 0, 0};
        cmp_obs("skip_wrap", 4);

        drive(4'hF, 1'b1, '0, 32'h7777_7777);
        drive(4'hF, 1'b0, '0, 32'h7777_7777);
        do_reset();
        obs_sel.delete();
        obs_data.delete();
        drive(4'hF, 1'b1, '0, 32'h8888_8888);
        idle(2);
        exp_sel = '{0, 0, 0, 0, 0, 0, 0, 0};
        cmp_obs("mid_reset", 1);

        if (LOCK_EN) begin
            do_reset();
            drive(4'b0001, 1'b1, '0, 32'h0000_0001);
            idle(1);
            obs_sel.delete();
            obs_data.delete();
            drive(4'b0111, 1'b1, 4'b0010, 32'h0003_0200);
            drive(4'b0111, 1'b1, 4'b0010, 32'h0003_0200);
            drive(4'b0111, 1'b1, 4'b0000, 32'h0003_0200);
            drive(4'b0111, 1'b1, 4'b0000, 32'h0003_0200);
            drive(4'b0111, 1'b1, 4'b0000, 32'h0003_0200);
            idle(2);
            exp_sel = '{1, 1, 1, 2, 0, 0, 0, 0};
            cmp_obs("lock", 5);
            drive(4'b0111, 1'b1, 4'b0010, 32'h0003_0200);
            drive(4'b0101, 1'b1, 4'b0000, 32'h0003_0200);
            chk("lock_block_ready", 32'(in_ready), 0);
            do_reset();
            obs_sel.delete();
            obs_data.delete();
            drive(4'b0111, 1'b1, 4'b0000, 32'h0003_0200);
            idle(2);
            exp_sel = '{0, 0, 0, 0, 0, 0, 0, 0};
            cmp_obs("lock_reset", 1);
        end

        for (int i = 0; i < 600; i++)
            drive(N'($urandom), $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? N'($urandom) : '0, $urandom);
        idle(3);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        @(negedge clk);
        v3 = 3'b111;
        d3 = {16'hA002, 16'hA001, 16'hA000};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #3;
            chk("n3_valid", 32'(ov3), 1);
            chk("n3_sel", 32'(os3), 32'(i % 3));
            chk("n3_data", 32'(od3), 32'hA000 + 32'(i % 3));
        end
        v3 = '0;
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muxnx1_rr_pipe.md
Name: muxnx1_rr_pipe

Overview:
- Parametrised successor to the 2:1 mux family: an N-input, WIDTH-bit multiplexer.
- Select comes from an internal round-robin arbiter instead of an external select line.
- Output is registered and uses a valid/ready handshake on every channel.
- Merges several producer streams onto one consumer path; throughput is one word per clock.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 8, data bits per channel.
- SEL_W, $clog2(N), width of the grant/select index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; combinational, one-hot or zero.
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accept.
- out_data  output  WIDTH  registered data.
- out_sel  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0, lock state cleared. in_ready=0 while rst=1.
- Slot availability: slot_free = !out_valid | out_ready.
- Arbitration (combinational): search channels ptr, ptr+1, ..., ptr+N-1 (mod N) for the first with in_valid=1. That channel is g.
- in_ready[g] = slot_free; all other in_ready bits are 0. If no channel is valid, in_ready=0.
- Transfer: in_valid[g] & in_ready[g]. On the next edge, out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= (g+1) mod N.
- Drain without refill: out_valid & out_ready with no transfer clears out_valid on the next edge. out_data and out_sel keep their last values.
- Simultaneous drain and transfer: the register is overwritten with the new word; out_valid stays 1, so back-to-back words flow with no bubble.
- Latency: 1 clock from input transfer to out_valid/out_data.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_sel are held stable and in_ready=0.
- Fairness: with all N channels continuously valid and out_ready=1, the grant order is 0,1,...,N-1,0,... A channel waits at most N-1 grants.
- ptr does not move when there is no transfer.
- Wrap: when g=N-1, ptr wraps to 0. For non-power-of-two N, ptr never takes values >= N.
- Reset mid-operation: any held word is discarded, out_valid drops asynchronously, and arbitration restarts from channel 0.
- No internal buffering beyond the single output register; there is no combinational path from in_data to out_data.

Optional Feature:
- Macro MUXNX1_LOCK_EN.
- Defined: adds input port in_lock (N bits, placed after in_data).
- If channel g transfers with in_lock[g]=1, the arbiter locks to g. Only g may be granted, even if g drops in_valid, until g transfers a word with in_lock[g]=0. That word releases the lock and sets ptr=(g+1) mod N.
- rst clears the lock.
- Not defined: the in_lock port is absent and arbitration is pure round-robin.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately. After release with only in_valid[2]=1 and data 0xA5 -> next cycle out_valid=1, out_data=0xA5, out_sel=2.
- Full contention: N=4, all valid, data k=0x10+k, out_ready=1 -> out_sel sequence 0,1,2,3,0 and out_data 0x10,0x11,0x12,0x13,0x10, with no idle cycles.
- Backpressure: hold out_ready=0 for 3 cycles with a word held -> out_data/out_sel unchanged, in_ready=0. Then raise out_ready=1 -> the next word is accepted in the same cycle the held word drains.
- Skip and wrap: after a grant to channel 3 (ptr=0), only channels 1 and 3 valid -> next grant is 1, then 3, then 1.
- Non-power-of-two: N=3, WIDTH=16, all valid -> out_sel sequence 0,1,2,0, never 3.
- Lock (MUXNX1_LOCK_EN): channel 1 sends 3 words with in_lock=1,1,0 while channels 0 and 2 are valid -> out_sel sequence 1,1,1,2,0. Reset during the lock -> the next grant goes to channel 0.
